grid_frame_arbiter: RTL and testbench
=====================================

Name: grid_frame_arbiter

Overview:
Owns the 16x16 frame image feeding the LED matrix driver. Shares a back buffer between two pixel requesters: game renderer (0) and overlay/score/splash renderer (1). Copies the finished back buffer to the front buffer ("grid") only on a display frame boundary, so the driver never shows a half-drawn frame. Sits between game logic and the matrix driver's grid input.

Parameters:
HOLD_MAX, 1024, cycles a requester may hold the grant without committing before forced revoke
RR_EN_DEFAULT, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 1 wins

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  2  per-requester access request, held until granted
gnt  out  2  one-hot grant; at most one bit set
wr_en  in  2  per-requester pixel write strobe
wr_row  in  2x4  per-requester row index 0..15
wr_col  in  2x4  per-requester column index 0..15
wr_pix  in  2  per-requester pixel value
commit  in  2  per-requester "frame complete"; releases grant and requests swap
frame_tick  in  1  one-cycle pulse from display side at refresh boundary
grid  out  16x16  front buffer, grid[row][col]
swap_done  out  1  one-cycle pulse when grid updated
timeout_err  out  1  one-cycle pulse on forced grant revoke

Behaviour:
- Reset: grid=0, back buffer=0, gnt=0, swap_done=0, timeout_err=0, state=IDLE, rr_last=1 (requester 0 served first), hold counter=0. Reset mid-operation discards the pending swap and grant.
- States: IDLE, GRANT, SWAP_WAIT, plus CLEAR when FRAME_CLEAR_EN is defined.
- IDLE: if any req, next cycle GRANT with gnt set.
  - Round-robin: winner is the requester not equal to rr_last when both request. Fixed priority: requester 1 wins.
  - rr_last updates on grant.
- GRANT: a write occurs on the clock edge when gnt[i] & wr_en[i]: back[wr_row[i]][wr_col[i]] <= wr_pix[i]. Writes from the non-granted requester are ignored, with no side effect.
- GRANT, commit[i] & gnt[i]: a same-cycle wr_en is applied first. Next state SWAP_WAIT; gnt cleared on the next edge. commit from a non-granted requester is ignored.
- GRANT, hold counter reaches HOLD_MAX-1 without commit: gnt cleared, timeout_err pulses, state IDLE. No swap; back-buffer writes are retained.
- SWAP_WAIT: waits for frame_tick.
  - A tick in the same cycle as the commit is not consumed; the swap takes the next tick.
  - On tick: grid <= back (full copy, back retained for incremental drawing); swap_done pulses next cycle; state IDLE, or CLEAR if enabled.
- frame_tick outside SWAP_WAIT: ignored.
- req is not sampled in SWAP_WAIT or CLEAR. Requesters keep req high and are granted later.
- Latency: req to gnt = 1 cycle from IDLE. commit to grid update = next frame_tick + 1 edge.
- Row/col are 4-bit and always in range; no wrap logic.

Optional Feature:
FRAME_CLEAR_EN
- Defined: after each swap, CLEAR zeroes one back-buffer row per cycle, rows 0..15 (16 cycles), then IDLE. grid is untouched.
- Not defined: CLEAR does not exist; back buffer persists across swaps.

Decomposition:
- Package display_pkg: GRID_DIM=16, typedef grid_t (logic [15:0][15:0]), typedef coord_t (logic [3:0]), requester enum {REQ_GAME=0, REQ_OVERLAY=1}, state enum.
- Sub-module rr_arbiter2: 2-way round-robin/fixed-priority grant logic with rr_last register.
- Top block holds the FSM, buffers and hold counter.

Test Plan:
- Reset then req=2'b01 -> gnt=2'b01 one cycle later; grid=0, swap_done=0.
- Requester 0 writes (3,5)=1 and (15,15)=1, commits, frame_tick 4 cycles later -> grid[3][5]=1 and grid[15][15]=1 only after the tick edge; swap_done pulses once.
- req=2'b11 for two consecutive frames (round-robin) -> grants 01 then 10. Same with RR_EN_DEFAULT=0 -> 10 both times.
- Granted requester 1 never commits, HOLD_MAX=8 -> gnt drops after 8 cycles; timeout_err pulses; grid unchanged.
- commit and frame_tick in the same cycle -> no swap on that tick; swap on the next tick. A non-granted requester's wr_en to (0,0) leaves the back buffer unchanged.
- FRAME_CLEAR_EN defined: swap, then 16 cycles with no grant; the next frame drawn with no writes commits grid=0. Reset asserted during SWAP_WAIT -> grid=0 and the pending swap is dropped.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types for the LED-matrix frame path: grid geometry, pixel coordinate,
// requester identities and the frame arbiter state encoding.
// Optional build macro: FRAME_CLEAR_EN adds the ST_CLEAR state.
// -----------------------------------------------------------------------------
package display_pkg;

   localparam int GRID_DIM = 16;

   // grid[row][col], one bit per LED
   typedef logic [GRID_DIM-1:0][GRID_DIM-1:0] grid_t;
   typedef logic [3:0] coord_t;

   typedef enum logic {
      REQ_GAME    = 1'b0,
      REQ_OVERLAY = 1'b1
   } req_id_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_GRANT     = 2'd1,
      ST_SWAP_WAIT = 2'd2
`ifdef FRAME_CLEAR_EN
      , ST_CLEAR   = 2'd3
`endif
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way grant selector. With RR_EN=1 a double request goes to the requester
// that was not served last; with RR_EN=0 requester 1 always wins.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_req      : per-requester request
//   i_take     : the winner is actually granted this cycle (updates history)
//   o_gnt      : one-hot winner (combinational), 0 when nobody requests
//   o_valid    : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter2
   import display_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic [1:0] o_gnt,
   output logic       o_valid
);

   req_id_t r_rr_last;
   req_id_t w_winner;

   always_comb begin
      w_winner = REQ_GAME;
      if (i_req == 2'b11) begin
         if (RR_EN)
            w_winner = (r_rr_last == REQ_OVERLAY) ? REQ_GAME : REQ_OVERLAY;
         else
            w_winner = REQ_OVERLAY;
      end else if (i_req[1]) begin
         w_winner = REQ_OVERLAY;
      end
   end

   assign o_valid = |i_req;
   assign o_gnt   = o_valid ? {w_winner == REQ_OVERLAY, w_winner == REQ_GAME} : 2'b00;

   // Reset to OVERLAY so that the game renderer is served first
   always_ff @(posedge clk) begin
      if (reset)
         r_rr_last <= REQ_OVERLAY;
      else if (i_take && o_valid)
         r_rr_last <= w_winner;
   end

endmodule

// File: rtl/grid_frame_arbiter.sv
// -----------------------------------------------------------------------------
// grid_frame_arbiter
// Owns the 16x16 frame for the LED matrix driver. Two renderers share a back
// buffer under a one-hot grant; a committed frame is copied to the front
// buffer (grid) only on a display frame_tick so the driver never sees a
// half-drawn image. A grant held too long without commit is revoked.
// Optional build macro: FRAME_CLEAR_EN -- after each swap the back buffer is
// zeroed one row per cycle (16 cycles) before new grants are accepted.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req[1:0]    : access request per requester (0 = game, 1 = overlay)
//   gnt[1:0]    : one-hot grant
//   wr_en/wr_row/wr_col/wr_pix : per-requester pixel write port
//   commit[1:0] : frame complete, releases grant and requests a swap
//   frame_tick  : display refresh boundary pulse
//   grid        : front buffer, grid[row][col]
//   swap_done   : one-cycle pulse after grid is updated
//   timeout_err : one-cycle pulse on forced grant revoke
// -----------------------------------------------------------------------------
module grid_frame_arbiter
   import display_pkg::*;
#(
   parameter int HOLD_MAX      = 1024,
   parameter bit RR_EN_DEFAULT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   output logic [1:0]       gnt,
   input  logic [1:0]       wr_en,
   input  coord_t [1:0]     wr_row,
   input  coord_t [1:0]     wr_col,
   input  logic [1:0]       wr_pix,
   input  logic [1:0]       commit,
   input  logic             frame_tick,
   output grid_t            grid,
   output logic             swap_done,
   output logic             timeout_err
);

   localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           r_state;
   logic [1:0]       r_gnt;
   logic [CNT_W-1:0] r_hold;
   grid_t            r_back;
   grid_t            r_grid;
   logic             r_swap_done;
   logic             r_timeout;
`ifdef FRAME_CLEAR_EN
   coord_t           r_clr_row;
`endif

   logic [1:0] w_arb_gnt;
   logic       w_arb_valid;
   logic       w_take;

   // Requests are only looked at in IDLE
   assign w_take = (r_state == ST_IDLE);

   rr_arbiter2 #(
      .RR_EN (RR_EN_DEFAULT)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_req   (req),
      .i_take  (w_take),
      .o_gnt   (w_arb_gnt),
      .o_valid (w_arb_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_gnt       <= 2'b00;
         r_hold      <= '0;
         r_back      <= '0;
         r_grid      <= '0;
         r_swap_done <= 1'b0;
         r_timeout   <= 1'b0;
`ifdef FRAME_CLEAR_EN
         r_clr_row   <= '0;
`endif
      end else begin
         r_swap_done <= 1'b0;
         r_timeout   <= 1'b0;

         // gnt is only ever set in GRANT, so this also gates writes by state;
         // a write in the commit cycle lands before the swap is armed
         for (int i = 0; i < 2; i++) begin
            if (r_gnt[i] && wr_en[i])
               r_back[wr_row[i]][wr_col[i]] <= wr_pix[i];
         end

         case (r_state)
            ST_IDLE: begin
               if (w_arb_valid) begin
                  r_gnt   <= w_arb_gnt;
                  r_hold  <= '0;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (|(commit & r_gnt)) begin
                  r_gnt   <= 2'b00;
                  r_state <= ST_SWAP_WAIT;
               end else if (r_hold == HOLD_LAST) begin
                  r_gnt     <= 2'b00;
                  r_timeout <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            ST_SWAP_WAIT: begin
               if (frame_tick) begin
                  r_grid      <= r_back;
                  r_swap_done <= 1'b1;
`ifdef FRAME_CLEAR_EN
                  r_clr_row   <= '0;
                  r_state     <= ST_CLEAR;
`else
                  r_state     <= ST_IDLE;
`endif
               end
            end
`ifdef FRAME_CLEAR_EN
            ST_CLEAR: begin
               r_back[r_clr_row] <= '0;
               r_clr_row         <= r_clr_row + 4'd1;
               if (r_clr_row == 4'd15)
                  r_state <= ST_IDLE;
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign grid        = r_grid;
   assign swap_done   = r_swap_done;
   assign timeout_err = r_timeout;

endmodule

// File: tb/tb_grid_frame_arbiter.sv
module tb_grid_frame_arbiter;
   import display_pkg::*;

   logic         clk;
   logic         reset;
   logic [1:0]   req;
   logic [1:0]   wr_en;
   coord_t [1:0] wr_row;
   coord_t [1:0] wr_col;
   logic [1:0]   wr_pix;
   logic [1:0]   commit;
   logic         frame_tick;

   logic [1:0]   gnt, gnt_fp;
   grid_t        grid, grid_fp;
   logic         swap_done, swap_done_fp;
   logic         timeout_err, timeout_err_fp;

   int n_checks = 0;
   int n_fail   = 0;

   grid_frame_arbiter #(.HOLD_MAX(8), .RR_EN_DEFAULT(1'b1)) dut (
      .clk(clk), .reset(reset), .req(req), .gnt(gnt),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_pix(wr_pix),
      .commit(commit), .frame_tick(frame_tick), .grid(grid),
      .swap_done(swap_done), .timeout_err(timeout_err)
   );

   grid_frame_arbiter #(.HOLD_MAX(8), .RR_EN_DEFAULT(1'b0)) dut_fp (
      .clk(clk), .reset(reset), .req(req), .gnt(gnt_fp),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_pix(wr_pix),
      .commit(commit), .frame_tick(frame_tick), .grid(grid_fp),
      .swap_done(swap_done_fp), .timeout_err(timeout_err_fp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   grid_t exp_g;
   int    n;

   initial begin
      reset = 1'b1; req = '0; wr_en = '0; wr_row = '0; wr_col = '0;
      wr_pix = '0; commit = '0; frame_tick = 1'b0;
      step(); step();
      reset = 1'b0;
      check("rst_gnt", gnt, 2'b00);
      check("rst_grid", grid, '0);
      check("rst_swap", swap_done, 1'b0);
      check("rst_to", timeout_err, 1'b0);

      // single request from game renderer
      req = 2'b01; step();
      check("gnt_req0", gnt, 2'b01);
      check("grid_zero", grid, '0);
      check("swap_idle", swap_done, 1'b0);
      req = 2'b00;

      // draw two pixels, commit, tick later
      wr_en = 2'b01; wr_row[0] = 4'd3; wr_col[0] = 4'd5; wr_pix = 2'b01; step();
      wr_row[0] = 4'd15; wr_col[0] = 4'd15; step();
      wr_en = 2'b00; commit = 2'b01; step();
      check("gnt_after_commit", gnt, 2'b00);
      commit = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         check("grid_before_tick", grid, '0);
         check("swap_before_tick", swap_done, 1'b0);
      end
      frame_tick = 1'b1; step();
      exp_g = '0; exp_g[3][5] = 1'b1; exp_g[15][15] = 1'b1;
      check("grid_swap1", grid, exp_g);
      check("swap_pulse", swap_done, 1'b1);
      frame_tick = 1'b0; step();
      check("swap_once", swap_done, 1'b0);

      // both requesting over two frames, round-robin vs fixed priority
      reset = 1'b1; step(); reset = 1'b0;
      req = 2'b11; step();
      check("rr_first", gnt, 2'b01);
      check("fp_first", gnt_fp, 2'b10);
      commit = 2'b11; step();
      check("rr_commit", gnt, 2'b00);
      commit = 2'b00; frame_tick = 1'b1; step();
      check("rr_swap", swap_done, 1'b1);
      frame_tick = 1'b0; step();
      check("rr_second", gnt, 2'b10);
      check("fp_second", gnt_fp, 2'b10);
      req = 2'b00;

      // requester 1 never commits; non-granted requester 0 tries (0,0)
      n = 0;
      while (gnt == 2'b10 && n < 20) begin
         if (n == 0) begin
            wr_en = 2'b11; wr_row = {4'd7, 4'd0}; wr_col = {4'd2, 4'd0}; wr_pix = 2'b11;
         end else begin
            wr_en = 2'b00;
         end
         check("to_not_yet", timeout_err, 1'b0);
         n++;
         step();
      end
      wr_en = 2'b00;
      check("hold_cycles", n, 8);
      check("to_gnt_drop", gnt, 2'b00);
      check("to_pulse", timeout_err, 1'b1);
      check("to_grid", grid, '0);
      step();
      check("to_once", timeout_err, 1'b0);

      // commit and tick together: tick not consumed
      req = 2'b01; step();
      check("gnt_ct", gnt, 2'b01);
      req = 2'b00; commit = 2'b01; frame_tick = 1'b1; step();
      check("ct_no_swap", swap_done, 1'b0);
      commit = 2'b00; frame_tick = 1'b0; step();
      check("ct_grid_hold", grid, '0);
      check("ct_swap_hold", swap_done, 1'b0);
      frame_tick = 1'b1; step();
      exp_g = '0; exp_g[7][2] = 1'b1;
      check("ct_grid", grid, exp_g);
      check("ct_swap", swap_done, 1'b1);
      frame_tick = 1'b0;

      // write in the commit cycle is kept
      req = 2'b01; step();
      check("gnt_wc", gnt, 2'b01);
      req = 2'b00; wr_en = 2'b01; wr_row[0] = 4'd1; wr_col[0] = 4'd1; wr_pix = 2'b01;
      commit = 2'b01; step();
      wr_en = 2'b00; commit = 2'b00; frame_tick = 1'b1; step();
      exp_g[1][1] = 1'b1;
      check("wc_grid", grid, exp_g);
      frame_tick = 1'b0;

      // reset while a swap is pending
      req = 2'b01; step();
      req = 2'b00; commit = 2'b01; step();
      commit = 2'b00; reset = 1'b1; step(); reset = 1'b0;
      check("rs_grid", grid, '0);
      check("rs_gnt", gnt, 2'b00);
      frame_tick = 1'b1; step();
      check("rs_no_swap", swap_done, 1'b0);
      check("rs_grid2", grid, '0);
      frame_tick = 1'b0;

`ifdef FRAME_CLEAR_EN
      req = 2'b01; step();
      wr_en = 2'b01; wr_row[0] = 4'd2; wr_col[0] = 4'd2; wr_pix = 2'b01; commit = 2'b01; step();
      wr_en = 2'b00; commit = 2'b00; frame_tick = 1'b1; step();
      exp_g = '0; exp_g[2][2] = 1'b1;
      check("clr_grid", grid, exp_g);
      frame_tick = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("clr_no_gnt", gnt, 2'b00);
         step();
      end
      step();
      check("clr_regrant", gnt, 2'b01);
      req = 2'b00; commit = 2'b01; step();
      commit = 2'b00; frame_tick = 1'b1; step();
      check("clr_empty", grid, '0);
      frame_tick = 1'b0;
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
